mem_access_stage: RTL and testbench

//  Consumer end of the EX/MEM pipeline buffer. Takes the registered EX/MEM fields and drives
//  the data-memory request/ready handshake, stalling upstream while a load/store is outstanding.

---
 rtl/mem_access_stage.sv | 156 +++++++++++++++
 tb/tb_mem_access_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory request/ready handshake, stalls upstream
// while an access is outstanding, resolves the branch and registers the MEM/WB fields.
module mem_access_stage #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] exmem_branch_target,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic [WIDTH-1:0] exmem_wdata,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_zero,
    input  logic             exmem_branch,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             exmem_memtoreg,
    input  logic             exmem_regwrite,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ready,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             stall,
    output logic             pc_src,
    output logic [WIDTH-1:0] pc_branch_target,
    output logic [WIDTH-1:0] memwb_read_data,
    output logic [WIDTH-1:0] memwb_alu_result,
    output logic [4:0]       memwb_rd,
    output logic             memwb_memtoreg,
    output logic             memwb_regwrite,
    output logic             mem_fault
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_access;
    logic            w_misaligned;
    logic            w_req;
    logic            w_stall;
    logic            w_abort;
    logic            w_complete;
    logic            w_fault;
    logic            r_fault;
    logic [WIDTH-1:0] r_read_data;
    logic [WIDTH-1:0] r_alu_result;
    logic [4:0]      r_rd;
    logic            r_memtoreg;
    logic            r_regwrite;

    assign w_access     = exmem_memread | exmem_memwrite;
    assign w_misaligned = w_access & (exmem_result[1:0] != 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access && !w_misaligned) begin
                    w_req = 1'b1;
                    if (!dmem_ready) begin
                        w_stall     = 1'b1;
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    w_req       = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CW'(TIMEOUT_CYCLES)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_req     = 1'b1;
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // Handshake outputs are quiet for the whole reset, even if EX/MEM still holds an access.
        if (reset) begin
            w_req   = 1'b0;
            w_stall = 1'b0;
            w_abort = 1'b0;
        end
    end

    assign w_complete = w_req & dmem_ready;
    assign w_fault    = w_misaligned | w_abort;

    // All pipeline buffers update on the falling edge.
    always_ff @(negedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_fault      <= 1'b0;
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_rd         <= '0;
            r_memtoreg   <= 1'b0;
            r_regwrite   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_fault) begin
                r_fault <= 1'b1;
            end
            if (w_stall) begin
                r_memtoreg <= 1'b0;
                r_regwrite <= 1'b0;
            end else begin
                r_alu_result <= exmem_result;
                r_rd         <= exmem_rd;
                r_memtoreg   <= exmem_memtoreg;
                r_regwrite   <= exmem_regwrite & ~w_fault;
                if (w_complete && exmem_memread) begin
                    r_read_data <= dmem_rdata;
                end
            end
        end
    end

    assign dmem_req         = w_req;
    assign dmem_we          = w_req & exmem_memwrite;
    assign dmem_addr        = exmem_result;
    assign dmem_wdata       = exmem_wdata;
    assign stall            = w_stall;
    assign pc_src           = exmem_branch & exmem_zero;
    assign pc_branch_target = exmem_branch_target;
    assign memwb_read_data  = r_read_data;
    assign memwb_alu_result = r_alu_result;
    assign memwb_rd         = r_rd;
    assign memwb_memtoreg   = r_memtoreg;
    assign memwb_regwrite   = r_regwrite;
    assign mem_fault        = r_fault;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: scoreboarded MEM/WB results plus per-cycle handshake checks.
module tb_mem_access_stage;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] exmem_branch_target, exmem_result, exmem_wdata;
    logic [4:0]  exmem_rd;
    logic        exmem_zero, exmem_branch, exmem_memread, exmem_memwrite;
    logic        exmem_memtoreg, exmem_regwrite;
    logic        dmem_req, dmem_we, dmem_ready, stall, pc_src;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, pc_branch_target;
    logic [31:0] memwb_read_data, memwb_alu_result;
    logic [4:0]  memwb_rd;
    logic        memwb_memtoreg, memwb_regwrite, mem_fault;

    mem_access_stage #(.WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .exmem_branch_target(exmem_branch_target), .exmem_result(exmem_result),
        .exmem_wdata(exmem_wdata), .exmem_rd(exmem_rd), .exmem_zero(exmem_zero),
        .exmem_branch(exmem_branch), .exmem_memread(exmem_memread),
        .exmem_memwrite(exmem_memwrite), .exmem_memtoreg(exmem_memtoreg),
        .exmem_regwrite(exmem_regwrite), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall(stall), .pc_src(pc_src),
        .pc_branch_target(pc_branch_target), .memwb_read_data(memwb_read_data),
        .memwb_alu_result(memwb_alu_result), .memwb_rd(memwb_rd),
        .memwb_memtoreg(memwb_memtoreg), .memwb_regwrite(memwb_regwrite),
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        m2r;
        logic        rw;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        tb_retired = 1'b0;
    logic        exp_fault  = 1'b0;
    logic [31:0] exp_rdata  = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // MEM/WB monitor: memwb only moves on the falling edge, so the rising edge is a quiet sample point.
    always @(posedge clk) begin
        if (tb_retired) begin
            exp_t e;
            tb_retired = 1'b0;
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                check_eq("memwb_rd", memwb_rd, e.rd);
                check_eq("memwb_alu", memwb_alu_result, e.alu);
                check_eq("memwb_rdata", memwb_read_data, e.rdata);
                check_eq("memwb_m2r", memwb_memtoreg, e.m2r);
                check_eq("memwb_rw", memwb_regwrite, e.rw);
            end
        end
    end

    task automatic clear_fields();
        exmem_branch_target = '0; exmem_result = '0; exmem_wdata = '0; exmem_rd = '0;
        exmem_zero = 0; exmem_branch = 0; exmem_memread = 0; exmem_memwrite = 0;
        exmem_memtoreg = 0; exmem_regwrite = 0; dmem_ready = 0; dmem_rdata = '0;
    endtask

    // wait_n: cycles before ready is raised (0 = zero-wait, negative = never).
    task automatic issue(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic m2r, input logic rw,
                         input int wait_n, input logic br, input logic zr,
                         input logic [31:0] tgt);
        logic acc_ok, mis, abort_exp, done, rdy, ab, e_req, e_stall;
        exp_t e;
        mis       = (ld | st) & (addr[1:0] != 2'b00);
        acc_ok    = (ld | st) & !mis;
        abort_exp = acc_ok & ((wait_n < 0) || (wait_n > TMO));
        if (ld && acc_ok && !abort_exp) exp_rdata = rdata;
        e.rd = rd; e.alu = addr; e.rdata = exp_rdata; e.m2r = m2r;
        e.rw = rw & !mis & !abort_exp;
        sb_q.push_back(e);
        exp_fault = exp_fault | mis | abort_exp;
        done = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            rdy = (k == wait_n);
            exmem_memread = ld; exmem_memwrite = st; exmem_result = addr;
            exmem_wdata = wdata; exmem_rd = rd; exmem_memtoreg = m2r;
            exmem_regwrite = rw; exmem_branch = br; exmem_zero = zr;
            exmem_branch_target = tgt;
            dmem_ready = rdy;
            dmem_rdata = rdy ? rdata : ~rdata;
            #1;
            ab      = acc_ok && (k == TMO) && !rdy;
            e_req   = acc_ok && !ab;
            e_stall = e_req && !rdy;
            check_eq("dmem_req", dmem_req, e_req);
            check_eq("stall", stall, e_stall);
            check_eq("dmem_we", dmem_we, e_req & st);
            check_eq("pc_src", pc_src, br & zr);
            if (e_req) begin
                check_eq("dmem_addr", dmem_addr, addr);
                check_eq("dmem_wdata", dmem_wdata, wdata);
            end
            if (br) check_eq("pc_target", pc_branch_target, tgt);
            @(negedge clk); #1;
            if (!e_stall) begin
                done = 1'b1;
                break;
            end
            check_eq("bubble_rw", memwb_regwrite, 0);
            check_eq("bubble_m2r", memwb_memtoreg, 0);
            @(posedge clk);
        end
        if (!done) check_eq("retire_budget", done, 1);
        check_eq("mem_fault", mem_fault, exp_fault);
        tb_retired = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        clear_fields();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_rw", memwb_regwrite, 0);
        check_eq("rst_m2r", memwb_memtoreg, 0);
        check_eq("rst_rd", memwb_rd, 0);
        check_eq("rst_alu", memwb_alu_result, 0);
        check_eq("rst_rdata", memwb_read_data, 0);
        check_eq("rst_fault", mem_fault, 0);
        check_eq("rst_req", dmem_req, 0);
        check_eq("rst_stall", stall, 0);
        @(posedge clk);
        reset = 1'b0;

        issue(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 5'd5, 1, 1, 0, 0, 0, 32'h0);
        issue(0, 1, 32'h20, 32'h12345678, 32'h0, 5'd0, 0, 0, 3, 0, 0, 32'h0);
        issue(1, 0, 32'h30, 32'h0, 32'h11111111, 5'd7, 1, 1, -1, 0, 0, 32'h0);
        issue(1, 0, 32'h34, 32'h0, 32'hCAFEF00D, 5'd8, 1, 1, 1, 0, 0, 32'h0);
        issue(1, 0, 32'h13, 32'h0, 32'h22222222, 5'd9, 1, 1, 0, 0, 0, 32'h0);
        issue(0, 1, 32'h22, 32'hAAAA5555, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
        // ALU op with a branch; ready pulses with no access and must be ignored
        issue(0, 0, 32'h99, 32'h0, 32'h0, 5'd3, 0, 1, 0, 1, 1, 32'h40);
        issue(0, 0, 32'h9C, 32'h0, 32'h0, 5'd4, 0, 1, 0, 1, 0, 32'h80);

        // Reset while a load sits in WAIT
        @(posedge clk);
        exmem_memread = 1; exmem_memwrite = 0; exmem_result = 32'h50; exmem_rd = 5'd9;
        exmem_regwrite = 1; exmem_memtoreg = 1; exmem_branch = 0; dmem_ready = 0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("prerst_stall", stall, 1);
        @(posedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        check_eq("midrst_req", dmem_req, 0);
        check_eq("midrst_stall", stall, 0);
        check_eq("midrst_fault", mem_fault, 0);
        check_eq("midrst_rw", memwb_regwrite, 0);
        check_eq("midrst_rdata", memwb_read_data, 0);
        @(posedge clk);
        clear_fields();
        reset = 1'b0;
        exp_fault = 1'b0;
        exp_rdata = '0;
        #1;
        check_eq("postrst_req", dmem_req, 0);
        check_eq("postrst_stall", stall, 0);

        // Ready on the last permitted WAIT cycle completes; one later aborts
        issue(1, 0, 32'h60, 32'h0, 32'h0BADF00D, 5'd10, 1, 1, TMO, 0, 0, 32'h0);
        issue(1, 0, 32'h64, 32'h0, 32'h33333333, 5'd11, 1, 1, TMO + 1, 0, 0, 32'h0);
        issue(1, 0, 32'h68, 32'h0, 32'h44444444, 5'd12, 1, 1, 2, 0, 0, 32'h0);

        @(posedge clk);
        clear_fields();
        repeat (2) @(posedge clk);
        #1;
        check_eq("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
